ram_cmd_ctrl: RTL and testbench
===============================

# ram_cmd_ctrl

Command front-end for the 64×32 synchronous RAM (`ram_sync`). It accepts packed 39-bit memory commands over a valid/ready handshake and buffers them in a small FIFO. It replays them in order onto the RAM's `writeOn`/`address`/`data_in` pins and returns read data over a second valid/ready channel. It sits directly upstream of `ram_sync` and replaces free-running stimulus with a flow-controlled command stream.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the write and read statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_in`  in  39  packed command: [38:33] address, [32] write flag (1 = write), [31:0] write data (ignored for reads).
- `cmd_valid`  in  1  `cmd_in` is valid.
- `cmd_ready`  out  1  FIFO can accept a command; equals `!full`.
- `rsp_data`  out  32  read data.
- `rsp_addr`  out  6  address of the read that produced `rsp_data`.
- `rsp_valid`  out  1  read response is valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `ram_writeOn`  out  1  drives the RAM's `writeOn`.
- `ram_address`  out  6  drives the RAM's `address`.
- `ram_data_in`  out  32  drives the RAM's `data_in`.
- `ram_data_out`  in  32  the RAM's `data_out`; registered read, valid one clock after the address is sampled.
- `wr_cnt`  out  CNT_W  number of writes issued; wraps modulo 2^CNT_W.
- `rd_cnt`  out  CNT_W  number of read responses accepted; wraps modulo 2^CNT_W.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

## Operation
- Push: a command is enqueued on a rising edge where `cmd_valid && cmd_ready`. `cmd_ready` depends only on `full`.
  - When full, no push occurs, even if a pop happens in the same cycle.
- FIFO has no bypass. A command pushed into an empty FIFO can be popped on the next cycle at the earliest.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, load the RAM pin registers, and go to ISSUE. `ram_writeOn` takes the command's flag.
  - ISSUE: the RAM samples its pins at the end of this cycle.
    - Write: clear `ram_writeOn`, increment `wr_cnt`, go to IDLE.
    - Read: go to WAIT.
  - WAIT: capture `ram_data_out` into `rsp_data` and `ram_address` into `rsp_addr`. Set `rsp_valid`, go to RESP.
  - RESP: hold `rsp_valid`, `rsp_data` and `rsp_addr` stable until `rsp_ready`. On that edge, clear `rsp_valid`, increment `rd_cnt`, go to IDLE.
- `ram_writeOn` is high for exactly one cycle per write command and never outside ISSUE.
- `ram_address`/`ram_data_in` hold their last values outside ISSUE.
- Ordering: strictly in order, so a read after a write to the same address returns the new data.
- A stalled response (`rsp_ready` low) blocks issue. The FIFO keeps accepting until full.
- Reset (asynchronous, any state):
  - FSM to IDLE, FIFO emptied.
  - Cleared to 0: `ram_writeOn`, `ram_address`, `ram_data_in`, `rsp_data`, `rsp_addr`, `rsp_valid`, `wr_cnt`, `rd_cnt`, `busy`.
  - `cmd_ready` is 1.
  - An in-flight write is aborted: `writeOn` drops immediately.

## Timing
- Push at edge E: earliest ISSUE is the cycle after E+1. The RAM write occurs at the end of that ISSUE cycle.
- Write throughput is 1 command per 2 cycles (IDLE, ISSUE).
- Read latency, from the pop edge (IDLE→ISSUE) to `rsp_valid` high: 2 edges.
- Read throughput with `rsp_ready` tied high is 1 per 4 cycles.
- All outputs are registered, except `cmd_ready` and `busy`, which are derived from registered state only. There are no combinational input-to-output paths.

## Structure
- Package `ram_ctrl_pkg`:
  - Constants: `ADDR_W`=6, `DATA_W`=32, `CMD_W`=39.
  - Field positions: `CMD_ADDR_HI`=38, `CMD_ADDR_LO`=33, `CMD_WR_BIT`=32.
  - FSM state enum: IDLE, ISSUE, WAIT, RESP.
- Sub-module `cmd_fifo`: parameterised width/depth, synchronous FIFO with `full`/`empty`. It uses an extra pointer bit to tell full from empty, so wrap-around is exact.

## Test plan
- Reset then idle:
  - `cmd_ready`=1, `busy`=0, `ram_writeOn` never high, all counters 0.
- Write then read back:
  - Push {6'd5,1,32'hDEADBEEF}, then {6'd5,0,0}.
  - Required: exactly one `ram_writeOn` pulse at address 5.
  - Required: `rsp_valid` with `rsp_data`=32'hDEADBEEF, `rsp_addr`=5; `wr_cnt`=1, `rd_cnt`=1.
- Back-pressure:
  - Hold `rsp_ready`=0 and push 1 read plus 4 writes.
  - Required: `cmd_ready` drops after the FIFO fills; `rsp_data` stays stable.
  - Release `rsp_ready`: the remaining writes issue in order.
- Full boundary:
  - With the FIFO full and a pop in the same cycle, assert `cmd_valid`.
  - Required: no push that cycle; the command is accepted on the next cycle.
- Address wrap:
  - Write 32'h1 to address 63 and 32'h2 to address 0, then read both.
  - Required: reads return 1 and 2 respectively.
- Mid-operation reset:
  - Assert `rst_n`=0 during ISSUE of a write to address 7.
  - Required: `ram_writeOn` low immediately, FIFO empty, counters 0.
  - A subsequent read of address 7 returns its pre-reset value.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared constants and FSM state type for the RAM command front-end.
package ram_ctrl_pkg;

    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 32;
    localparam int CMD_W       = 39;
    localparam int CMD_ADDR_HI = 38;
    localparam int CMD_ADDR_LO = 33;
    localparam int CMD_WR_BIT  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; an extra pointer bit separates full from empty.
module cmd_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/ram_cmd_ctrl.sv
// Flow-controlled command front-end replaying buffered commands onto ram_sync.
//   state | meaning
//   IDLE  | waiting for a queued command; pops head and loads RAM pins
//   ISSUE | RAM samples pins at end of cycle; writes finish here
//   WAIT  | registered RAM read data arrives; captured into response
//   RESP  | response held until the consumer accepts it
module ram_cmd_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              ram_writeOn,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic              busy
);

    state_t           state;
    logic [CMD_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign cmd_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ram_writeOn doubles as the write flag of the command in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ram_writeOn <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            rsp_data    <= '0;
            rsp_addr    <= '0;
            rsp_valid   <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        ram_address <= head[CMD_ADDR_HI:CMD_ADDR_LO];
                        ram_data_in <= head[DATA_W-1:0];
                        ram_writeOn <= head[CMD_WR_BIT];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ram_writeOn) begin
                        ram_writeOn <= 1'b0;
                        wr_cnt      <= wr_cnt + 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_data  <= ram_data_out;
                    rsp_addr  <= ram_address;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rd_cnt    <= rd_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Self-checking bench for ram_cmd_ctrl with a behavioural RAM and in-order scoreboard.
module tb_ram_cmd_ctrl;

    typedef struct {
        logic [5:0]  addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } ad_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [38:0] cmd_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        ram_writeOn;
    logic [5:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic [7:0]  wr_cnt;
    logic [7:0]  rd_cnt;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram_mem    [64];
    logic [31:0] commit_mem [64];
    logic [31:0] spec_mem   [64];
    ad_t         exp_wr[$];
    ad_t         exp_rd[$];
    ad_t         e;
    int          pushed_wr = 0;
    int          pushed_rd = 0;
    int          n_we = 0;
    logic        prev_we = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] s_data;
    logic [5:0]  s_addr;
    vec_t        vecs[6];

    always #5 clk = ~clk;

    ram_cmd_ctrl #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_in       (cmd_in),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .ram_writeOn  (ram_writeOn),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .wr_cnt       (wr_cnt),
        .rd_cnt       (rd_cnt),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural ram_sync: write on writeOn, registered read.
    always @(posedge clk) begin
        if (ram_writeOn) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    // Scoreboard: commands are applied to a speculative memory in push order;
    // only writes actually seen on the pins are committed, so reset can discard
    // everything still queued or in flight.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_wr.delete();
            exp_rd.delete();
            for (int i = 0; i < 64; i++) spec_mem[i] = commit_mem[i];
            pushed_wr = 0;
            pushed_rd = 0;
            stall     = 1'b0;
            prev_we   = 1'b0;
        end else begin
            if (ram_writeOn) begin
                n_we++;
                check("we_single_cycle", prev_we, 0);
                check("we_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("we_addr", ram_address, e.a);
                    check("we_data", ram_data_in, e.d);
                end
                commit_mem[ram_address] = ram_data_in;
            end
            prev_we = ram_writeOn;
            if (stall) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_data", rsp_data, s_data);
                check("rsp_hold_addr", rsp_addr, s_addr);
            end
            stall  = rsp_valid && !rsp_ready;
            s_data = rsp_data;
            s_addr = rsp_addr;
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    check("rsp_data", rsp_data, e.d);
                    check("rsp_addr", rsp_addr, e.a);
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_in[32]) begin
                    spec_mem[cmd_in[38:33]] = cmd_in[31:0];
                    exp_wr.push_back('{a: cmd_in[38:33], d: cmd_in[31:0]});
                    pushed_wr++;
                end else begin
                    exp_rd.push_back('{a: cmd_in[38:33], d: spec_mem[cmd_in[38:33]]});
                    pushed_rd++;
                end
            end
        end
    end

    task automatic push(input logic [38:0] c);
        int n = 0;
        cmd_in    = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i]    = 32'h0;
            commit_mem[i] = 32'h0;
            spec_mem[i]   = 32'h0;
        end
        ram_data_out = 32'h0;
        vecs[0] = '{addr: 6'd5,  wr: 1'b1, data: 32'hDEADBEEF, exp: 32'h0};
        vecs[1] = '{addr: 6'd5,  wr: 1'b0, data: 32'h0,        exp: 32'hDEADBEEF};
        vecs[2] = '{addr: 6'd63, wr: 1'b1, data: 32'h1,        exp: 32'h0};
        vecs[3] = '{addr: 6'd0,  wr: 1'b1, data: 32'h2,        exp: 32'h0};
        vecs[4] = '{addr: 6'd63, wr: 1'b0, data: 32'h0,        exp: 32'h1};
        vecs[5] = '{addr: 6'd0,  wr: 1'b0, data: 32'h0,        exp: 32'h2};

        rst_n     = 1'b0;
        cmd_in    = '0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_writeon", ram_writeOn, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ram_address", ram_address, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_no_we", n_we, 0);
        check("idle_wr_cnt", wr_cnt, 0);
        check("idle_rd_cnt", rd_cnt, 0);

        // Write/read-back and address wrap vectors.
        for (int i = 0; i < 6; i++) begin
            push({vecs[i].addr, vecs[i].wr, vecs[i].data});
            if (!vecs[i].wr) begin
                wait_rsp();
                check("tbl_rsp_data", rsp_data, vecs[i].exp);
                check("tbl_rsp_addr", rsp_addr, vecs[i].addr);
            end
            wait_idle();
            if (i == 1) begin
                check("wb_we_pulses", n_we, 1);
                check("wb_wr_cnt", wr_cnt, 1);
                check("wb_rd_cnt", rd_cnt, 1);
            end
        end
        check("tbl_wr_cnt", wr_cnt, 3);
        check("tbl_rd_cnt", rd_cnt, 3);

        // Back-pressure: a stalled read blocks issue while writes fill the FIFO.
        rsp_ready = 1'b0;
        push({6'd5, 1'b0, 32'h0});
        for (int i = 0; i < 4; i++) push({6'(10 + i), 1'b1, 32'hA000_0000 + i});
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_data", rsp_data, 32'hDEADBEEF);
        repeat (4) @(negedge clk);
        check("bp_still_full", cmd_ready, 0);
        check("bp_data_stable", rsp_data, 32'hDEADBEEF);
        check("bp_wr_cnt", wr_cnt, 3);

        // Full boundary: command offered while full, pop happens that same cycle.
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_in    = {6'd20, 1'b1, 32'h2020};
        cmd_valid = 1'b1;
        check("fb_full_ready", cmd_ready, 0);
        @(negedge clk);
        check("fb_after_pop_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        check("fb_wr_cnt", wr_cnt, 8);
        check("fb_rd_cnt", rd_cnt, 4);
        push({6'd20, 1'b0, 32'h0});
        wait_rsp();
        check("fb_readback", rsp_data, 32'h2020);
        wait_idle();
        push({6'd13, 1'b0, 32'h0});
        wait_rsp();
        check("bp_last_write", rsp_data, 32'hA000_0003);
        wait_idle();

        // Mid-operation reset during ISSUE of a write to address 7.
        push({6'd7, 1'b1, 32'h77});
        wait_idle();
        push({6'd7, 1'b1, 32'hBAD});
        begin
            int n = 0;
            while (!ram_writeOn && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("mr_in_issue", ram_writeOn, 1);
        rst_n = 1'b0;
        #1;
        check("mr_we_dropped", ram_writeOn, 0);
        check("mr_cmd_ready", cmd_ready, 1);
        check("mr_busy", busy, 0);
        check("mr_wr_cnt", wr_cnt, 0);
        check("mr_rd_cnt", rd_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push({6'd7, 1'b0, 32'h0});
        wait_rsp();
        check("mr_pre_reset_value", rsp_data, 32'h77);
        check("mr_rsp_addr", rsp_addr, 7);
        wait_idle();
        check("mr_after_rd_cnt", rd_cnt, 1);
        check("mr_after_wr_cnt", wr_cnt, 0);

        // Randomized traffic with random back-pressure, checked by the scoreboard.
        for (int i = 0; i < 600; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_in    = {6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'($urandom)};
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("rnd_wr_drained", exp_wr.size(), 0);
        check("rnd_rd_drained", exp_rd.size(), 0);
        check("rnd_wr_cnt", wr_cnt, 8'(pushed_wr));
        check("rnd_rd_cnt", rd_cnt, 8'(pushed_rd));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
